// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with a small LIFO return-address stack.
// Each enabled cycle the PC advances, jumps, calls (push) or returns (pop).
module pc_stack_unit #(
  parameter int          AW         = 8,
  parameter int          DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pc_mux_sel,
  input  logic [AW-1:0] jump_addr,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] sp_q, sp_d;
  logic          err_q, err_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [AW-1:0] stack_q [DEPTH];

  logic [AW-1:0] pc_inc_s;
  logic [IW-1:0] top_idx_s;
  logic [IW-1:0] push_idx_s;
  logic          push_s;
  logic          sp_empty_s;
  logic          sp_full_s;

  assign pc_inc_s   = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign sp_empty_s = (sp_q == {PW{1'b0}});
  assign sp_full_s  = (sp_q == PW'(DEPTH));
  assign top_idx_s  = IW'(sp_q - {{(PW-1){1'b0}}, 1'b1});
  assign push_idx_s = IW'(sp_q);

  // Next-state selection; ret outranks jump/call, which outrank sequential advance.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    err_d  = err_q;
    push_s = 1'b0;
    if (en) begin
      if (ret) begin
        if (!sp_empty_s) begin
          pc_d = stack_q[top_idx_s];
          sp_d = sp_q - {{(PW-1){1'b0}}, 1'b1};
        end else begin
          pc_d  = pc_inc_s;
          err_d = 1'b1;
        end
      end else if (pc_mux_sel) begin
        pc_d = jump_addr;
        if (call) begin
          if (!sp_full_s) begin
            push_s = 1'b1;
            sp_d   = sp_q + {{(PW-1){1'b0}}, 1'b1};
          end else begin
            err_d = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end else begin
        pc_d = pc_inc_s;
      end
    end else begin
      pc_d = pc_q;
    end
    empty_d = (sp_d == {PW{1'b0}});
    full_d  = (sp_d == PW'(DEPTH));
  end

  // PC, pointer and status flags; reset wins over any pending action.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_ADDR;
      sp_q    <= {PW{1'b0}};
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Return-address storage; contents need no reset since the pointer gates reads.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      stack_q[push_idx_s] <= pc_inc_s;
    end
  end

  assign pc          = pc_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a behavioural model predicts each cycle's
// outputs, queued at drive time and compared after the clock edge.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst, en, pc_mux_sel, call, ret;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       stack_empty, stack_full, stack_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_err;

  pc_stack_unit #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_mux_sel(pc_mux_sel),
    .jump_addr(jump_addr), .call(call), .ret(ret), .pc(pc),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle, predict with the model, then compare after the edge.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic [7:0] a, input logic c, input logic t);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; pc_mux_sel = s; jump_addr = a; call = c; ret = t;
    if (r) begin
      m_pc = 8'h00; m_stack.delete(); m_err = 1'b0;
    end else if (e) begin
      if (t) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
      end else if (s) begin
        if (c) begin
          if (m_stack.size() < 4) m_stack.push_back(m_pc + 8'd1);
          else m_err = 1'b1;
        end
        m_pc = a;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    x.pc = m_pc; x.empty = (m_stack.size() == 0); x.full = (m_stack.size() == 4); x.err = m_err;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_underrun", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check_eq("pc", {24'd0, pc}, {24'd0, x.pc});
      check_eq("empty", {31'd0, stack_empty}, {31'd0, x.empty});
      check_eq("full", {31'd0, stack_full}, {31'd0, x.full});
      check_eq("err", {31'd0, stack_err}, {31'd0, x.err});
    end
  endtask

  task automatic idle();             step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic jump(input logic [7:0] a);  step(1'b0, 1'b1, 1'b1, a, 1'b0, 1'b0); endtask
  task automatic do_call(input logic [7:0] a); step(1'b0, 1'b1, 1'b1, a, 1'b1, 1'b0); endtask
  task automatic do_ret();           step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1); endtask
  task automatic do_reset();         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc_mux_sel = 1'b0; jump_addr = 8'h00; call = 1'b0; ret = 1'b0;
    m_pc = 8'h00; m_err = 1'b0;

    do_reset();
    check_eq("rst_pc", {24'd0, pc}, 32'h00);
    check_eq("rst_empty", {31'd0, stack_empty}, 32'd1);
    idle(); idle(); idle();
    check_eq("seq_pc3", {24'd0, pc}, 32'h03);

    jump(8'h40);
    check_eq("jump_pc", {24'd0, pc}, 32'h40);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("stall_pc", {24'd0, pc}, 32'h40);

    // call without pc_mux_sel must not push
    step(1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    check_eq("call_nosel_pc", {24'd0, pc}, 32'h41);

    jump(8'h10);
    do_call(8'h80);
    do_call(8'h90);
    check_eq("call2_pc", {24'd0, pc}, 32'h90);
    do_ret();
    check_eq("ret1_pc", {24'd0, pc}, 32'h81);
    do_ret();
    check_eq("ret2_pc", {24'd0, pc}, 32'h11);
    check_eq("ret2_empty", {31'd0, stack_empty}, 32'd1);

    do_call(8'hB0); do_call(8'hB4); do_call(8'hB8); do_call(8'hBC);
    check_eq("fill_full", {31'd0, stack_full}, 32'd1);
    check_eq("fill_err", {31'd0, stack_err}, 32'd0);
    do_call(8'hA0);
    check_eq("ovf_pc", {24'd0, pc}, 32'hA0);
    check_eq("ovf_err", {31'd0, stack_err}, 32'd1);
    do_ret(); check_eq("lifo0", {24'd0, pc}, 32'hB9);
    do_ret(); check_eq("lifo1", {24'd0, pc}, 32'hB5);
    do_ret(); check_eq("lifo2", {24'd0, pc}, 32'hB1);
    do_ret(); check_eq("lifo3", {24'd0, pc}, 32'h12);

    do_reset();
    check_eq("err_cleared", {31'd0, stack_err}, 32'd0);
    jump(8'h20);
    do_ret();
    check_eq("unf_pc", {24'd0, pc}, 32'h21);
    check_eq("unf_err", {31'd0, stack_err}, 32'd1);
    jump(8'h32);
    do_call(8'h50);
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    check_eq("ret_prio_pc", {24'd0, pc}, 32'h33);
    idle(); idle();
    check_eq("err_sticky", {31'd0, stack_err}, 32'd1);

    jump(8'hFF);
    idle();
    check_eq("wrap_pc", {24'd0, pc}, 32'h00);
    jump(8'hFF);
    do_call(8'h60);
    do_ret();
    check_eq("wrap_push", {24'd0, pc}, 32'h00);
    do_call(8'h70);
    step(1'b1, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
    check_eq("rst_call_pc", {24'd0, pc}, 32'h00);
    check_eq("rst_call_empty", {31'd0, stack_empty}, 32'd1);
    do_ret();
    check_eq("lost_push_pc", {24'd0, pc}, 32'h01);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 1), 8'($urandom_range(0, 255)),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    end

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
